// File: rtl/jtcps_obj_pkg.sv
// rtl/jtcps_obj_pkg.sv - shared types, field positions and helpers for the object scanner
package jtcps_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ZONE  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // attr word field positions
    localparam int ATTR_TM    = 12;   // tile_m, 4 bits
    localparam int ATTR_TN    = 8;    // tile_n, 4 bits
    localparam int ATTR_NOOFF = 7;
    localparam int ATTR_VFLIP = 6;
    localparam int ATTR_HFLIP = 5;

    // hardware position offsets of the object layer
    localparam logic [9:0] OBJ_YOFS = 10'h10;
    localparam logic [9:0] OBJ_XOFS = 10'h40;

    // attr[15:8] value that terminates the table
    localparam logic [7:0] END_MARK = 8'hFF;

    // first idle channel after 'last', wrapping over nch channels
    function automatic logic [1:0] rr_pick(input logic [3:0] idle,
                                           input logic [1:0] last,
                                           input int         nch);
        logic [1:0] pick;
        logic       found;
        logic [1:0] idx2;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx  = (int'(last) + k) % nch;
            idx2 = 2'(idx);
            if (!found && k <= nch && idle[idx2]) begin
                pick  = idx2;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtcps_obj_zone.sv
// rtl/jtcps_obj_zone.sv - registered vertical zone test and tile code expansion
module jtcps_obj_zone (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  vrenderf,
    input  logic [9:0]  obj_y,
    input  logic [3:0]  tile_m,
    input  logic        vflip,
    input  logic [3:0]  n,
    input  logic [15:0] code,
    output logic        inzone,
    output logic [3:0]  vsub,
    output logic [15:0] code_mn
);

    logic [9:0] d;
    logic [9:0] lim;
    logic [3:0] row;

    // line distance into the object, its height in lines and the tile row hit
    always_comb begin
        d   = {1'b0, vrenderf} - obj_y;
        lim = {1'b0, {1'b0, tile_m} + 5'd1, 4'd0};
        row = vflip ? tile_m - d[7:4] : d[7:4];
    end

    // nibble adds wrap inside their nibble, matching the tile ROM layout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inzone  <= 1'b0;
            vsub    <= 4'd0;
            code_mn <= 16'd0;
        end else begin
            inzone  <= d < lim;
            vsub    <= d[3:0] ^ {4{vflip}};
            code_mn <= {code[15:8], code[7:4] + row, code[3:0] + n};
        end
    end

endmodule

// File: rtl/jtcps_obj_scan_mc.sv
// rtl/jtcps_obj_scan_mc.sv - per-line object table scanner feeding NCH tile drawers
module jtcps_obj_scan_mc
    import jtcps_obj_pkg::*;
#(
    parameter int AW      = 10,
    parameter int NCH     = 2,
    parameter int RD_LAT  = 1,
    parameter int MAXTILE = 256,
    localparam int CW     = $clog2(MAXTILE + 1)
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flip,
    input  logic [8:0]     vrender,
    input  logic           start,
    input  logic [9:0]     off_x,
    input  logic [9:0]     off_y,
    output logic [AW-1:0]  table_addr,
    input  logic [15:0]    table_x,
    input  logic [15:0]    table_y,
    input  logic [15:0]    table_code,
    input  logic [15:0]    table_attr,
    output logic [NCH-1:0] dr_start,
    input  logic [NCH-1:0] dr_idle,
    output logic [15:0]    dr_code,
    output logic [15:0]    dr_attr,
    output logic [8:0]     dr_hpos,
    output logic [2:0]     dr_prio,
    output logic [1:0]     dr_bank,
    output logic           line_done,
    output logic           overflow,
    output logic [CW-1:0]  tile_cnt
);

    state_t      state;
    logic        start_l;
    logic [8:0]  vrf;
    logic [1:0]  lat_cnt;
    logic [9:0]  obj_x, obj_y;
    logic [3:0]  tile_n, tile_m, n, npos;
    logic        vflip, hflip;
    logic [15:0] code;
    logic [7:0]  attr_lo;
    logic [2:0]  prio;
    logic [1:0]  bank;
    logic        ovf_pend;
    logic [1:0]  last_ch;

    logic        z_inzone;
    logic [3:0]  z_vsub;
    logic [15:0] z_code_mn;

    logic        start_edge;
    logic [9:0]  eff_x;
    logic [3:0]  idle4;
    logic [1:0]  pick;
    logic [3:0]  pick_oh;
    logic        any_idle;
    logic        cnt_full;
    logic        unused_bits;

    assign unused_bits = ^{table_x[12:10], table_y[12:10]};

    jtcps_obj_zone u_zone (
        .clk      (clk),
        .rst_n    (rst_n),
        .vrenderf (vrf),
        .obj_y    (obj_y),
        .tile_m   (tile_m),
        .vflip    (vflip),
        .n        (n),
        .code     (code),
        .inzone   (z_inzone),
        .vsub     (z_vsub),
        .code_mn  (z_code_mn)
    );

    // edge detect, tile position and drawer channel selection
    always_comb begin
        start_edge       = start & ~start_l;
        eff_x            = obj_x + {2'b00, npos, 4'd0};
        idle4            = 4'd0;
        idle4[NCH-1:0]   = dr_idle;
        any_idle         = |idle4;
        pick             = rr_pick(idle4, last_ch, NCH);
        pick_oh          = 4'b0001 << pick;
        cnt_full         = tile_cnt == CW'(MAXTILE);
    end

    // scan FSM; a start edge restarts from entry 0 whatever the state.
    // The round-robin pointer restarts each line so channel 0 is preferred first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            start_l    <= 1'b0;
            vrf        <= 9'd0;
            lat_cnt    <= 2'd0;
            obj_x      <= 10'd0;
            obj_y      <= 10'd0;
            tile_n     <= 4'd0;
            tile_m     <= 4'd0;
            n          <= 4'd0;
            npos       <= 4'd0;
            vflip      <= 1'b0;
            hflip      <= 1'b0;
            code       <= 16'd0;
            attr_lo    <= 8'd0;
            prio       <= 3'd0;
            bank       <= 2'd0;
            ovf_pend   <= 1'b0;
            last_ch    <= 2'(NCH - 1);
            table_addr <= '0;
            dr_start   <= '0;
            dr_code    <= 16'd0;
            dr_attr    <= 16'd0;
            dr_hpos    <= 9'd0;
            dr_prio    <= 3'd0;
            dr_bank    <= 2'd0;
            line_done  <= 1'b0;
            overflow   <= 1'b0;
            tile_cnt   <= '0;
        end else begin
            start_l   <= start;
            dr_start  <= '0;
            line_done <= 1'b0;
            if (start_edge) begin
                table_addr <= '0;
                tile_cnt   <= '0;
                overflow   <= 1'b0;
                ovf_pend   <= 1'b0;
                last_ch    <= 2'(NCH - 1);
                vrf        <= vrender ^ {1'b0, {8{flip}}};
                lat_cnt    <= 2'd0;
                state      <= ST_FETCH;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_FETCH: begin
                        if (lat_cnt == 2'(RD_LAT - 1)) begin
                            state <= ST_EVAL;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end
                    ST_EVAL: begin
                        if (table_y[15] || table_attr[15:8] == END_MARK) begin
                            state <= ST_DONE;
                        end else begin
                            obj_y   <= table_y[9:0] + OBJ_YOFS -
                                       (table_attr[ATTR_NOOFF] ? 10'd0 : off_y);
                            obj_x   <= table_x[9:0] + OBJ_XOFS -
                                       (table_attr[ATTR_NOOFF] ? 10'd0 : off_x);
                            tile_n  <= table_attr[ATTR_TN +: 4];
                            tile_m  <= table_attr[ATTR_TM +: 4];
                            vflip   <= table_attr[ATTR_VFLIP];
                            hflip   <= table_attr[ATTR_HFLIP];
                            n       <= 4'd0;
                            npos    <= table_attr[ATTR_HFLIP] ? table_attr[ATTR_TN +: 4] : 4'd0;
                            code    <= table_code;
                            attr_lo <= table_attr[7:0];
                            prio    <= table_x[15:13];
                            bank    <= table_y[14:13];
                            state   <= ST_ZONE;
                        end
                    end
                    ST_ZONE: state <= ST_ISSUE;
                    ST_ISSUE: begin
                        if (!z_inzone) begin
                            if (&table_addr) begin
                                state <= ST_DONE;
                            end else begin
                                table_addr <= table_addr + 1'b1;
                                lat_cnt    <= 2'd0;
                                state      <= ST_FETCH;
                            end
                        end else if (eff_x[9] || cnt_full || any_idle) begin
                            if (!eff_x[9]) begin
                                if (cnt_full) begin
                                    ovf_pend <= 1'b1;
                                end else begin
                                    dr_start <= pick_oh[NCH-1:0];
                                    dr_code  <= z_code_mn;
                                    dr_attr  <= {4'd0, z_vsub, attr_lo};
                                    dr_hpos  <= eff_x[8:0] - 9'd1;
                                    dr_prio  <= prio;
                                    dr_bank  <= bank;
                                    tile_cnt <= tile_cnt + CW'(1);
                                    last_ch  <= pick;
                                end
                            end
                            if (n != tile_n) begin
                                n     <= n + 4'd1;
                                npos  <= hflip ? npos - 4'd1 : npos + 4'd1;
                                state <= ST_ZONE;
                            end else if (&table_addr) begin
                                state <= ST_DONE;
                            end else begin
                                table_addr <= table_addr + 1'b1;
                                lat_cnt    <= 2'd0;
                                state      <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        line_done <= 1'b1;
                        overflow  <= ovf_pend;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtcps_obj_scan_mc.sv
// tb/tb_jtcps_obj_scan_mc.sv - directed self-checking bench for jtcps_obj_scan_mc
module tb_jtcps_obj_scan_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flip;
    logic [8:0]  vrender;
    logic        start;
    logic [9:0]  off_x, off_y;
    logic [9:0]  table_addr;
    logic [15:0] table_x, table_y, table_code, table_attr;
    logic [1:0]  dr_start;
    logic [1:0]  dr_idle;
    logic [15:0] dr_code, dr_attr;
    logic [8:0]  dr_hpos;
    logic [2:0]  dr_prio;
    logic [1:0]  dr_bank;
    logic        line_done, overflow;
    logic [8:0]  tile_cnt;

    logic [15:0] ty [0:1023];
    logic [15:0] tx [0:1023];
    logic [15:0] tc [0:1023];
    logic [15:0] ta [0:1023];

    logic [1:0]  rec_start [0:1023];
    logic [15:0] rec_code  [0:1023];
    logic [15:0] rec_attr  [0:1023];
    logic [8:0]  rec_hpos  [0:1023];
    logic [2:0]  rec_prio  [0:1023];
    logic [1:0]  rec_bank  [0:1023];

    int n_pulse = 0;
    int n_done  = 0;
    int n_viol  = 0;
    logic       ovf_at_done = 1'b0;
    logic [8:0] cnt_at_done = 9'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    jtcps_obj_scan_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flip       (flip),
        .vrender    (vrender),
        .start      (start),
        .off_x      (off_x),
        .off_y      (off_y),
        .table_addr (table_addr),
        .table_x    (table_x),
        .table_y    (table_y),
        .table_code (table_code),
        .table_attr (table_attr),
        .dr_start   (dr_start),
        .dr_idle    (dr_idle),
        .dr_code    (dr_code),
        .dr_attr    (dr_attr),
        .dr_hpos    (dr_hpos),
        .dr_prio    (dr_prio),
        .dr_bank    (dr_bank),
        .line_done  (line_done),
        .overflow   (overflow),
        .tile_cnt   (tile_cnt)
    );

    initial forever #5 clk = ~clk;

    // frame table RAM with one cycle of read latency
    always @(posedge clk) begin
        table_y    <= ty[table_addr];
        table_x    <= tx[table_addr];
        table_code <= tc[table_addr];
        table_attr <= ta[table_addr];
    end

    // record every draw request and line end on the falling edge
    always @(negedge clk) begin
        if (dr_start != 2'b00) begin
            if (n_pulse < 1024) begin
                rec_start[n_pulse] = dr_start;
                rec_code[n_pulse]  = dr_code;
                rec_attr[n_pulse]  = dr_attr;
                rec_hpos[n_pulse]  = dr_hpos;
                rec_prio[n_pulse]  = dr_prio;
                rec_bank[n_pulse]  = dr_bank;
            end
            n_pulse++;
        end
        if ((dr_start & ~dr_idle) != 2'b00) n_viol++;
        if (line_done) begin
            n_done++;
            ovf_at_done = overflow;
            cnt_at_done = tile_cnt;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 1024; i++) begin
            ty[i] = 16'h8000;
            tx[i] = 16'h0000;
            tc[i] = 16'h0000;
            ta[i] = 16'h0000;
        end
    endtask

    task automatic set_obj(input int i, input logic [15:0] y, input logic [15:0] x,
                           input logic [15:0] c, input logic [15:0] a);
        ty[i] = y;
        tx[i] = x;
        tc[i] = c;
        ta[i] = a;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = n_done;
        ok   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (n_done != base) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({table_addr, dr_start, dr_code, dr_attr, dr_hpos, dr_prio, dr_bank,
             line_done, overflow, tile_cnt} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h start=%b code=%h cnt=%h want all zero",
                     table_addr, dr_start, dr_code, tile_cnt);
        end
    endtask

    task automatic test_single();
        int base;
        bit ok;
        clear_table();
        set_obj(0, 16'h4070, 16'hA030, 16'h0100, 16'h0003);
        vrender = 9'h080;
        base = n_pulse;
        do_start();
        wait_done(60, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL single_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", n_pulse - base); end
        n_cmp++;
        if (rec_start[base] !== 2'b01) begin n_fail++; $display("FAIL single_ch: got %b want 01", rec_start[base]); end
        n_cmp++;
        if (rec_hpos[base] !== 9'h06F) begin n_fail++; $display("FAIL single_hpos: got %h want 06f", rec_hpos[base]); end
        n_cmp++;
        if (rec_attr[base] !== 16'h0003) begin n_fail++; $display("FAIL single_attr: got %h want 0003", rec_attr[base]); end
        n_cmp++;
        if (rec_code[base] !== 16'h0100) begin n_fail++; $display("FAIL single_code: got %h want 0100", rec_code[base]); end
        n_cmp++;
        if (rec_prio[base] !== 3'd5) begin n_fail++; $display("FAIL single_prio: got %0d want 5", rec_prio[base]); end
        n_cmp++;
        if (rec_bank[base] !== 2'd2) begin n_fail++; $display("FAIL single_bank: got %0d want 2", rec_bank[base]); end
        n_cmp++;
        if (cnt_at_done !== 9'd1 || ovf_at_done !== 1'b0) begin
            n_fail++; $display("FAIL single_cnt_ovf: got cnt=%0d ovf=%b want cnt=1 ovf=0", cnt_at_done, ovf_at_done);
        end
        n_cmp++;
        if (table_addr !== 10'd1) begin n_fail++; $display("FAIL single_addr_hold: got %0d want 1", table_addr); end
    endtask

    task automatic test_multi_hflip();
        int base;
        bit ok;
        clear_table();
        set_obj(0, 16'h0070, 16'h0030, 16'h1230, 16'h0321);
        set_obj(1, 16'h0000, 16'h0000, 16'h0000, 16'hFF00);
        base = n_pulse;
        do_start();
        wait_done(80, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL multi_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 4) begin n_fail++; $display("FAIL multi_count: got %0d want 4", n_pulse - base); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rec_code[base+k] !== 16'h1230 + 16'(k)) begin
                n_fail++; $display("FAIL multi_code%0d: got %h want %h", k, rec_code[base+k], 16'h1230 + 16'(k));
            end
            n_cmp++;
            if (rec_hpos[base+k] !== 9'h09F - 9'(16 * k)) begin
                n_fail++; $display("FAIL multi_hpos%0d: got %h want %h", k, rec_hpos[base+k], 9'h09F - 9'(16 * k));
            end
            n_cmp++;
            if (rec_start[base+k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL multi_ch%0d: got %b want %b", k, rec_start[base+k], (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        n_cmp++;
        if (rec_attr[base] !== 16'h0021) begin n_fail++; $display("FAIL multi_attr: got %h want 0021", rec_attr[base]); end
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        clear_table();
        for (int i = 0; i < 300; i++) set_obj(i, 16'h0070, 16'h0030, 16'(i), 16'h0000);
        base = n_pulse;
        do_start();
        wait_done(3000, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL ovf_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 256) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 256", n_pulse - base); end
        n_cmp++;
        if (cnt_at_done !== 9'd256) begin n_fail++; $display("FAIL ovf_tile_cnt: got %0d want 256", cnt_at_done); end
        n_cmp++;
        if (ovf_at_done !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_at_done: got %b want 1", ovf_at_done); end
        n_cmp++;
        if (rec_code[base+255] !== 16'h00FF) begin n_fail++; $display("FAIL ovf_last_code: got %h want 00ff", rec_code[base+255]); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_held: got %b want 1", overflow); end
        clear_table();
        do_start();
        n_cmp++;
        if (overflow !== 1'b0 || tile_cnt !== 9'd0) begin
            n_fail++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d want ovf=0 cnt=0", overflow, tile_cnt);
        end
        wait_done(60, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL ovf_empty_done: got timeout want line_done"); end
    endtask

    task automatic test_backpressure();
        int base;
        int bad;
        bit ok;
        clear_table();
        set_obj(0, 16'h0070, 16'h0030, 16'h0ABC, 16'h0002);
        dr_idle = 2'b00;
        base = n_pulse;
        bad  = 0;
        do_start();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (dr_start !== 2'b00 || dr_code !== 16'h00FF || dr_hpos !== 9'h06F) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        n_cmp++;
        if (n_pulse != base) begin n_fail++; $display("FAIL bp_no_start: got %0d pulses want 0", n_pulse - base); end
        dr_idle = 2'b10;
        wait_done(40, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bp_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 1 || rec_start[base] !== 2'b10) begin
            n_fail++; $display("FAIL bp_grant: got %0d pulses ch=%b want 1 pulse ch=10", n_pulse - base, rec_start[base]);
        end
        n_cmp++;
        if (rec_code[base] !== 16'h0ABC || rec_attr[base] !== 16'h0002) begin
            n_fail++; $display("FAIL bp_data: got code=%h attr=%h want 0abc 0002", rec_code[base], rec_attr[base]);
        end
        n_cmp++;
        if (n_viol != 0) begin n_fail++; $display("FAIL bp_busy_start: got %0d violations want 0", n_viol); end
        dr_idle = 2'b11;
    endtask

    task automatic test_abort();
        int base;
        bit ok;
        clear_table();
        set_obj(0, 16'h0000, 16'h0030, 16'h0555, 16'h0000);
        set_obj(1, 16'h0070, 16'h0030, 16'h0777, 16'h0000);
        dr_idle = 2'b00;
        base = n_pulse;
        do_start();
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (table_addr !== 10'd1) begin n_fail++; $display("FAIL abort_pre_addr: got %0d want 1", table_addr); end
        dr_idle = 2'b11;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (dr_start !== 2'b00 || table_addr !== 10'd0) begin
            n_fail++; $display("FAIL abort_edge: got start=%b addr=%0d want 00 and 0", dr_start, table_addr);
        end
        wait_done(60, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL abort_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 1 || rec_code[base] !== 16'h0777) begin
            n_fail++; $display("FAIL abort_rescan: got %0d pulses code=%h want 1 pulse 0777", n_pulse - base, rec_code[base]);
        end
        n_cmp++;
        if (cnt_at_done !== 9'd1) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1", cnt_at_done); end
    endtask

    task automatic test_reset_flip();
        int base;
        bit ok;
        clear_table();
        set_obj(0, 16'h0070, 16'h0030, 16'h1230, 16'h0321);
        dr_idle = 2'b00;
        do_start();
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({table_addr, dr_start, dr_code, dr_attr, dr_hpos, dr_prio, dr_bank,
             line_done, overflow, tile_cnt} !== 70'd0) begin
            n_fail++;
            $display("FAIL midscan_reset: got addr=%h code=%h attr=%h hpos=%h want all zero",
                     table_addr, dr_code, dr_attr, dr_hpos);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dr_idle = 2'b11;
        clear_table();
        set_obj(0, 16'h006C, 16'h0030, 16'h4560, 16'h1045);
        flip    = 1'b1;
        vrender = 9'h080;
        base = n_pulse;
        do_start();
        wait_done(60, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL flip_done: got timeout want line_done"); end
        n_cmp++;
        if (n_pulse - base != 1 || rec_start[base] !== 2'b01) begin
            n_fail++; $display("FAIL flip_count: got %0d pulses ch=%b want 1 pulse ch=01", n_pulse - base, rec_start[base]);
        end
        n_cmp++;
        if (rec_attr[base] !== 16'h0C45) begin n_fail++; $display("FAIL flip_vsub: got %h want 0c45", rec_attr[base]); end
        n_cmp++;
        if (rec_code[base] !== 16'h4570) begin n_fail++; $display("FAIL flip_code: got %h want 4570", rec_code[base]); end
        n_cmp++;
        if (rec_hpos[base] !== 9'h06F) begin n_fail++; $display("FAIL flip_hpos: got %h want 06f", rec_hpos[base]); end
        flip = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        flip    = 1'b0;
        vrender = 9'h080;
        start   = 1'b0;
        off_x   = 10'd0;
        off_y   = 10'd0;
        dr_idle = 2'b11;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_single();
        test_multi_hflip();
        test_overflow();
        test_backpressure();
        test_abort();
        test_reset_flip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
